// File: rtl/riscv_defines.sv
// Shared types for the instruction fetch slice.
//   inst_t        : 32-bit instruction word
//   NOP_INST      : addi x0,x0,0, delivered with fault entries
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one instruction queue entry {inst, pc, fault}
package riscv_defines;

  typedef logic [31:0] inst_t;

  localparam inst_t NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_MISALIGN = 2'd1,
    ST_HALT     = 2'd2
  } fetch_state_t;

  typedef struct packed {
    inst_t       inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Parameterised synchronous FIFO with flush.
//   clk, rst_n      : clock, async active-low reset (empties the FIFO)
//   flush           : empties the FIFO at the next edge; wins over push/pop
//   push, push_data : write; accepted when not full, or when full and popping
//   pop             : read-advance; ignored when empty
//   head            : oldest entry (undefined content when empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries
module fetch_queue #(
  parameter  int DEPTH = 2,
  parameter  int W     = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, queues responses toward decode,
// handles redirects (drop of stale responses), misaligned targets and faults.
//   imem_req_*   : request channel (valid/ready)
//   imem_rsp_*   : in-order response channel, no backpressure
//   redirect_*   : branch/jump/trap/fence.i redirect
//   fetch_*      : instruction channel to decode (valid/ready)
//   dbg_state    : current FSM state
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// edge where valid and ready are both 1; a valid producer holds its payload
// stable until the transfer.
// Optional macro FETCH_BYPASS_EN: a response may appear on fetch_* in the
// cycle it arrives when the queue is empty (enqueued only if decode stalls).
module fetch_unit
  import riscv_defines::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_rsp_valid,
  input  inst_t        imem_rsp_data,
  input  logic         imem_rsp_err,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fetch_valid,
  input  logic         fetch_ready,
  output inst_t        fetch_inst,
  output logic [31:0]  fetch_pc,
  output logic         fetch_fault,
  output fetch_state_t dbg_state
);

  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int CSW = CW + 1;
  localparam int EW  = $bits(fetch_entry_t);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;

  fetch_entry_t  iq_push_data, iq_head, rsp_entry, out_entry;
  logic          iq_push, iq_pop, iq_full, iq_empty;
  logic [CW-1:0] iq_count;

  logic [31:0]   af_head;
  logic          af_flush, af_full, af_empty;
  logic [CW-1:0] af_count;

  logic          rsp_live, req_fire, bypass, misalign_ins;
  logic [CSW-1:0] credits_used;

  // A response belongs to the current stream only when nothing is pending
  // drop; in a redirect cycle every arriving response is stale.
  assign rsp_live = imem_rsp_valid && (drop_q == '0) && !redirect_valid && !af_empty;

  assign credits_used = CSW'(iq_count) + CSW'(af_count);

  // rst_n gates the request so the memory never sees one while in reset.
  // A faulting response stops issue in its own cycle.
  assign imem_req_valid = rst_n && (state_q == ST_FETCH) && !redirect_valid &&
                          (drop_q == '0) && !af_full &&
                          (credits_used < CSW'(QDEPTH)) &&
                          !(rsp_live && imem_rsp_err);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    rsp_entry.inst  = imem_rsp_err ? NOP_INST : imem_rsp_data;
    rsp_entry.pc    = af_head;
    rsp_entry.fault = imem_rsp_err;
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_live && iq_empty;
`else
  assign bypass = 1'b0;
`endif

  assign misalign_ins = (state_q == ST_MISALIGN) && (drop_q == '0) &&
                        !redirect_valid && !iq_full;

  always_comb begin
    iq_push_data = rsp_entry;
    if (misalign_ins) iq_push_data = '{inst: NOP_INST, pc: pc_q, fault: 1'b1};
  end

  // A bypassed response taken by decode this cycle never enters the queue.
  assign iq_push  = misalign_ins || (rsp_live && !(bypass && fetch_ready));
  assign iq_pop   = fetch_ready && !iq_empty;
  assign af_flush = redirect_valid || (rsp_live && imem_rsp_err);

  always_comb begin
    out_entry = '{inst: NOP_INST, pc: pc_q, fault: 1'b0};
    if (!iq_empty)   out_entry = iq_head;
    else if (bypass) out_entry = rsp_entry;
  end

  assign fetch_valid = !iq_empty || bypass;
  assign fetch_inst  = out_entry.inst;
  assign fetch_pc    = out_entry.pc;
  assign fetch_fault = out_entry.fault;
  assign dbg_state   = state_q;

  fetch_queue #(.DEPTH(QDEPTH), .W(EW)) u_inst_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (iq_push),
    .push_data (iq_push_data),
    .pop       (iq_pop),
    .head      (iq_head),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (iq_count)
  );

  // Address of every live outstanding request, popped by its response.
  fetch_queue #(.DEPTH(QDEPTH), .W(32)) u_addr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (af_flush),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_live),
    .head      (af_head),
    .full      (af_full),
    .empty     (af_empty),
    .count     (af_count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (req_fire) pc_d = pc_q + 32'd4;
    if ((drop_q != '0) && imem_rsp_valid) drop_d = drop_q - CW'(1);
    case (state_q)
      ST_FETCH: begin
        // Requests still in flight behind the faulting one become stale.
        if (rsp_live && imem_rsp_err) begin
          state_d = ST_HALT;
          drop_d  = af_count - CW'(1);
        end
      end
      ST_MISALIGN: if (misalign_ins) state_d = ST_HALT;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      // Everything still owed by the memory after this edge is stale.
      drop_d  = drop_q + af_count - CW'(imem_rsp_valid);
      state_d = (redirect_pc[1:0] != 2'b00) ? ST_MISALIGN : ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order random-latency memory, random decode
// backpressure, and a stream-level reference model of the expected fetches.
module tb_fetch_unit;
  import riscv_defines::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         imem_req_valid, imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid, imem_rsp_err;
  inst_t        imem_rsp_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         fetch_valid, fetch_ready, fetch_fault;
  inst_t        fetch_inst;
  logic [31:0]  fetch_pc;
  fetch_state_t dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_inst     (fetch_inst),
    .fetch_pc       (fetch_pc),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory and model state ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mem_q[$];
  logic [64:0] exp_q[$];          // {inst, pc, fault} in program order

  int checks = 0, errors = 0;
  int win = 0;
  int req_rdy_pct = 100, rsp_pct = 100, fetch_rdy_pct = 100;
  int lat_min = 1, lat_max = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;  // never a word address: no fault
  logic        rst_val = 1'b0, redir_now = 1'b0;
  logic [31:0] redir_target = '0;

  logic [31:0] req_exp_pc;
  int          inflight, stream_hs;
  bit          no_req, prev_hold;
  logic [64:0] prev_out;
  int          rel_win, first_valid;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0F0F;
  endfunction

  // Expected decode stream after (re)starting at t.
  task automatic load_stream(input logic [31:0] t);
    logic [31:0] pc;
    exp_q.delete();
    if (t[1:0] != 2'b00) begin
      exp_q.push_back({NOP_INST, t, 1'b1});
    end else begin
      for (int i = 0; i < 300; i++) begin
        pc = t + 32'(4 * i);
        if (pc == err_addr) begin
          exp_q.push_back({NOP_INST, pc, 1'b1});
          break;
        end
        exp_q.push_back({inst_of(pc), pc, 1'b0});
      end
    end
    req_exp_pc = t;
    inflight   = 0;
    stream_hs  = 0;
    no_req     = (t[1:0] != 2'b00);
    prev_hold  = 0;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic reset_checks();
    check("rst_req_valid",   imem_req_valid, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_fault", fetch_fault, 0);
    check("rst_fetch_inst",  fetch_inst, NOP_INST);
    check("rst_fetch_pc",    fetch_pc, RESET_PC);
    check("rst_state",       dbg_state, ST_FETCH);
    load_stream(RESET_PC);
  endtask

  task automatic monitor();
    logic [64:0] out, e;
    out = {fetch_inst, fetch_pc, fetch_fault};
    if (first_valid < 0 && fetch_valid) first_valid = win - rel_win;
    if (prev_hold) check("hold_stable", {fetch_valid, out}, {1'b1, prev_out});
    if (redirect_valid) check("redir_no_req", imem_req_valid, 0);
    else if (no_req)    check("halt_no_req", imem_req_valid, 0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, req_exp_pc);
      mem_q.push_back('{addr: imem_req_addr, due: win + int'($urandom_range(lat_min, lat_max))});
      req_exp_pc += 32'd4;
      inflight++;
      check("credit_limit", inflight <= QDEPTH, 1);
    end
    if (fetch_valid && fetch_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("fetch_unexpected", fetch_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("fetch_entry", out, e);
        inflight--;
        stream_hs++;
        if (e[0]) no_req = 1;
      end
    end
    prev_hold = fetch_valid && !fetch_ready && !redirect_valid;
    prev_out  = out;
    if (redirect_valid) load_stream(redirect_pc);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    @(negedge clk);
    win++;
    rst_n = rst_val;
    if (!rst_val) mem_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    if (rst_val && mem_q.size() > 0 && mem_q[0].due <= win &&
        int'($urandom_range(0, 99)) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_q[0].addr);
      imem_rsp_err   = (mem_q[0].addr == err_addr);
    end
    imem_req_ready = int'($urandom_range(0, 99)) < req_rdy_pct;
    fetch_ready    = int'($urandom_range(0, 99)) < fetch_rdy_pct;
    redirect_valid = redir_now && rst_val;
    redirect_pc    = redir_target;
    #1;
    if (!rst_n) reset_checks();
    else        monitor();
    if (imem_rsp_valid) void'(mem_q.pop_front());
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_now    = 1'b1;
    redir_target = t;
    step();
    redir_now    = 1'b0;
  endtask

  task automatic knobs(input int rq, input int rs, input int fr, input int lmin, input int lmax);
    req_rdy_pct = rq; rsp_pct = rs; fetch_rdy_pct = fr; lat_min = lmin; lat_max = lmax;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [31:0] t;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;
    first_valid = -1;
    load_stream(RESET_PC);

    // reset, then release with latency 1 and decode always ready
    rst_val = 1'b0;
    repeat (3) step();
    knobs(100, 100, 100, 1, 1);
    rel_win = win + 1;
    rst_val = 1'b1;
    repeat (12) step();
`ifdef FETCH_BYPASS_EN
    check("first_valid_cycle", first_valid, 1);
`else
    check("first_valid_cycle", first_valid, 2);
`endif
    check("startup_progress", stream_hs >= 3, 1);

    // decode stalls for 10 cycles, then random backpressure
    knobs(80, 80, 0, 1, 3);
    repeat (10) step();
    knobs(70, 70, 50, 1, 3);
    repeat (30) step();

    // redirect to 0x100 with requests still outstanding
    knobs(100, 100, 100, 4, 4);
    repeat (3) step();
    redirect(32'h0000_0100);
    knobs(80, 80, 70, 1, 3);
    repeat (20) step();
    check("redir_100_progress", stream_hs > 0, 1);

    // misaligned redirect: one fault entry, then silence until 0x200
    redirect(32'h0000_0102);
    knobs(80, 80, 60, 1, 3);
    repeat (15) step();
    check("misalign_delivered", exp_q.size(), 0);
    check("misalign_halt_state", dbg_state, ST_HALT);
    redirect(32'h0000_0200);
    repeat (20) step();
    check("resume_200_progress", stream_hs > 0, 1);

    // reset mid-operation with a full queue, restart with a fault at 0x8
    knobs(100, 100, 0, 1, 3);
    repeat (8) step();
    rst_val = 1'b0;
    repeat (2) step();
    err_addr = 32'h0000_0008;
    knobs(100, 100, 100, 1, 1);
    rst_val = 1'b1;
    load_stream(RESET_PC);
    repeat (15) step();
    check("fault_stream_len", stream_hs, 3);
    check("fault_halt_state", dbg_state, ST_HALT);
    err_addr = 32'hFFFF_FFFF;

    // pc wraparound
    redirect(32'hFFFF_FFF8);
    knobs(80, 80, 70, 1, 3);
    repeat (25) step();
    check("wrap_progress", stream_hs >= 4, 1);

    // random redirects, faults and backpressure
    for (int r = 0; r < 10; r++) begin
      t = {22'd0, 10'($urandom_range(0, 1023))};
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      err_addr = ($urandom_range(0, 2) == 0) ? t + 32'(4 * $urandom_range(0, 6)) : 32'hFFFF_FFFF;
      redirect(t);
      knobs(int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
            int'($urandom_range(20, 100)), 1, int'($urandom_range(1, 4)));
      repeat ($urandom_range(10, 40)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
